// File: rtl/serializer_pkg.sv
// rtl/serializer_pkg.sv - shared SERDES types used by serializer control and datapath
package serializer_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/serializer_if.sv
// rtl/serializer_if.sv - parallel-in / serial-out val/rdy bundle for the serializer
interface serializer_if #(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8
);

  logic                 recv_val;
  logic                 recv_rdy;
  logic [BIT_WIDTH-1:0] recv_msg [N_SAMPLES];
  logic                 send_val;
  logic                 send_rdy;
  logic [BIT_WIDTH-1:0] send_msg;

  modport master (
    output recv_val, recv_msg, send_rdy,
    input  recv_rdy, send_val, send_msg
  );

  modport slave (
    input  recv_val, recv_msg, send_rdy,
    output recv_rdy, send_val, send_msg
  );

endinterface

// File: rtl/serializer_ctrl.sv
// rtl/serializer_ctrl.sv - serializer FSM, word index counter and handshake generation
module serializer_ctrl
  import serializer_pkg::*;
#(
  parameter int N_SAMPLES = 8,
  localparam int CNT_W = $clog2(N_SAMPLES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             recv_val,
  output logic             recv_rdy,
  output logic             send_val,
  input  logic             send_rdy,
  output logic             capture,
  output logic [CNT_W-1:0] count
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(N_SAMPLES - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             last_word;
  logic             send_fire;

  always_comb begin
    last_word = (count_q == LAST);
    send_val  = !reset && (state_q == SEND);
    // Accepting on the last-word fire lets the next block follow with no bubble.
    recv_rdy  = !reset && ((state_q == IDLE) ||
                           ((state_q == SEND) && send_rdy && last_word));
    capture   = recv_val && recv_rdy;
    send_fire = send_val && send_rdy;

    state_d = state_q;
    count_d = count_q;
    case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = SEND;
          count_d = '0;
        end
      end
      SEND: begin
        if (send_fire) begin
          if (last_word) begin
            count_d = '0;
            state_d = capture ? SEND : IDLE;
          end else begin
            count_d = count_q + CNT_W'(1);
          end
        end
      end
      default: begin
        state_d = IDLE;
        count_d = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/serializer.sv
// rtl/serializer.sv - parallel-to-serial converter: block buffer plus count-indexed output mux
module serializer
  import serializer_pkg::*;
#(
  parameter int BIT_WIDTH = 32,
  parameter int N_SAMPLES = 8,
  localparam int CNT_W = $clog2(N_SAMPLES)
) (
  input  logic        clk,
  input  logic        reset,
  serializer_if.slave bus
);

  logic                 capture;
  logic [CNT_W-1:0]     count;
  logic [BIT_WIDTH-1:0] buffer_q [N_SAMPLES];
  logic [BIT_WIDTH-1:0] buffer_d [N_SAMPLES];

  serializer_ctrl #(
    .N_SAMPLES (N_SAMPLES)
  ) u_ctrl (
    .clk      (clk),
    .reset    (reset),
    .recv_val (bus.recv_val),
    .recv_rdy (bus.recv_rdy),
    .send_val (bus.send_val),
    .send_rdy (bus.send_rdy),
    .capture  (capture),
    .count    (count)
  );

  always_comb begin
    buffer_d = buffer_q;
    if (capture) begin
      buffer_d = bus.recv_msg;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N_SAMPLES; i++) begin
        buffer_q[i] <= '0;
      end
    end else begin
      buffer_q <= buffer_d;
    end
  end

  assign bus.send_msg = buffer_q[count];

endmodule
